// File: rtl/mdu_ctrl.sv
// Multiply/divide controller for the E stage: fixed-latency MULT/DIV with
// pending result registers, architectural HI/LO ownership and stall request.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_valid,
    input  logic [3:0]  md_op,
    input  logic        flush,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] md_rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;
    logic [31:0]     p_hi_q, p_hi_d;
    logic [31:0]     p_lo_q, p_lo_d;
    logic            upd_q, upd_d;

    logic            is_md;
    logic            fire;
    logic signed [63:0] smul;
    logic        [63:0] umul;
    logic signed [31:0] s_dvd, s_dvs, s_quo, s_rem;
    logic        [31:0] u_dvs, u_quo, u_rem;
    logic               div_zero;
    logic               div_ovf;

    assign busy      = (state_q == BUSY);
    assign is_md     = (md_op >= OP_MULT) && (md_op <= OP_MFLO);
    assign fire      = md_valid && is_md && !busy && !flush;
    assign stall_req = md_valid && is_md && busy;
    assign hi        = hi_q;
    assign lo        = lo_q;

    always_comb begin
        md_rdata = 32'd0;
        if (md_valid && !busy) begin
            if (md_op == OP_MFHI) begin
                md_rdata = hi_q;
            end else if (md_op == OP_MFLO) begin
                md_rdata = lo_q;
            end
        end
    end

    // Arithmetic datapath; divisor is forced non-zero so the divider never
    // sees a zero (the result is discarded in that case anyway).
    always_comb begin
        smul     = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
        umul     = {32'd0, rs_val} * {32'd0, rt_val};
        div_zero = (rt_val == 32'd0);
        div_ovf  = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);
        s_dvd    = $signed(rs_val);
        s_dvs    = (div_zero || div_ovf) ? 32'sd1 : $signed(rt_val);
        s_quo    = s_dvd / s_dvs;
        s_rem    = s_dvd % s_dvs;
        if (div_ovf) begin
            s_quo = 32'sh8000_0000;
            s_rem = 32'sd0;
        end
        u_dvs    = div_zero ? 32'd1 : rt_val;
        u_quo    = rs_val / u_dvs;
        u_rem    = rs_val % u_dvs;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;
        upd_d   = upd_q;

        case (state_q)
            IDLE: begin
                if (fire) begin
                    case (md_op)
                        OP_MULT: begin
                            p_hi_d  = smul[63:32];
                            p_lo_d  = smul[31:0];
                            upd_d   = 1'b1;
                            cnt_d   = CW'(MULT_CYCLES);
                            state_d = BUSY;
                        end
                        OP_MULTU: begin
                            p_hi_d  = umul[63:32];
                            p_lo_d  = umul[31:0];
                            upd_d   = 1'b1;
                            cnt_d   = CW'(MULT_CYCLES);
                            state_d = BUSY;
                        end
                        OP_DIV: begin
                            p_hi_d  = s_rem;
                            p_lo_d  = s_quo;
                            upd_d   = !div_zero;
                            cnt_d   = CW'(DIV_CYCLES);
                            state_d = BUSY;
                        end
                        OP_DIVU: begin
                            p_hi_d  = u_rem;
                            p_lo_d  = u_quo;
                            upd_d   = !div_zero;
                            cnt_d   = CW'(DIV_CYCLES);
                            state_d = BUSY;
                        end
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    if (upd_q) begin
                        hi_d = p_hi_q;
                        lo_d = p_lo_q;
                    end
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            p_hi_q  <= 32'd0;
            p_lo_q  <= 32'd0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            upd_q   <= upd_d;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed-vector bench for mdu_ctrl with hand-computed HI/LO expectations.
module tb_mdu_ctrl;

    logic        clk;
    logic        reset;
    logic        md_valid;
    logic [3:0]  md_op;
    logic        flush;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        stall_req;
    logic [31:0] md_rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec = 0;
    int n_err = 0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .md_valid  (md_valid),
        .md_op     (md_op),
        .flush     (flush),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .busy      (busy),
        .stall_req (stall_req),
        .md_rdata  (md_rdata),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        md_valid = 1'b0;
        md_op    = 4'd0;
        flush    = 1'b0;
    endtask

    // Fire one op at the next edge, then check busy holds for exactly ncyc cycles.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int ncyc);
        md_valid = 1'b1;
        md_op    = op;
        rs_val   = a;
        rt_val   = b;
        tick();
        idle_in();
        for (int i = 0; i < ncyc; i++) begin
            chk($sformatf("%s busy c%0d", tag, i), {31'd0, busy}, 32'd1);
            tick();
        end
        chk($sformatf("%s busy done", tag), {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int k;
        reset  = 1'b0;
        rs_val = 32'd0;
        rt_val = 32'd0;
        idle_in();
        #12;
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst stall", {31'd0, stall_req}, 32'd0);
        chk("rst rdata", md_rdata, 32'd0);
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);
        reset = 1'b1;
        tick();

        run_op("mult", 4'd1, 32'hFFFF_FFFD, 32'd7, 5);
        chk("mult hi", hi, 32'hFFFF_FFFF);
        chk("mult lo", lo, 32'hFFFF_FFEB);

        run_op("multu", 4'd2, 32'hFFFF_FFFD, 32'd7, 5);
        chk("multu hi", hi, 32'h0000_0006);
        chk("multu lo", lo, 32'hFFFF_FFEB);

        run_op("divu", 4'd4, 32'd100, 32'd7, 10);
        chk("divu hi", hi, 32'h0000_0002);
        chk("divu lo", lo, 32'h0000_000E);

        run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10);
        chk("div hi", hi, 32'hFFFF_FFFF);
        chk("div lo", lo, 32'hFFFF_FFFD);

        // DIV, then one ADD, then MFHI held under stall until busy drops.
        md_valid = 1'b1; md_op = 4'd3; rs_val = 32'd100; rt_val = 32'd7;
        tick();
        md_op = 4'd0;
        #1;
        chk("add no stall", {31'd0, stall_req}, 32'd0);
        tick();
        md_op = 4'd7;
        k = 0;
        #1;
        while (stall_req === 1'b1 && k < 30) begin
            chk($sformatf("mfhi rdata stalled %0d", k), md_rdata, 32'd0);
            k++;
            tick();
        end
        chk("stall count", k, 32'd9);
        chk("mfhi busy", {31'd0, busy}, 32'd0);
        chk("mfhi new hi", md_rdata, 32'h0000_0002);
        md_op = 4'd8;
        #1;
        chk("mflo new lo", md_rdata, 32'h0000_000E);
        idle_in();

        md_valid = 1'b1; md_op = 4'd5; rs_val = 32'h1234_5678;
        tick();
        chk("mthi", hi, 32'h1234_5678);
        md_op = 4'd6; rs_val = 32'h9ABC_DEF0;
        tick();
        chk("mtlo", lo, 32'h9ABC_DEF0);
        md_op = 4'd7;
        #1;
        chk("mfhi after mthi", md_rdata, 32'h1234_5678);
        idle_in();

        run_op("div0", 4'd3, 32'd55, 32'd0, 10);
        chk("div0 hi", hi, 32'h1234_5678);
        chk("div0 lo", lo, 32'h9ABC_DEF0);

        md_valid = 1'b1; md_op = 4'd1; rs_val = 32'd3; rt_val = 32'd4; flush = 1'b1;
        tick();
        chk("flush mult busy", {31'd0, busy}, 32'd0);
        md_op = 4'd6; rs_val = 32'hDEAD_BEEF;
        tick();
        chk("flush hi", hi, 32'h1234_5678);
        chk("flush mtlo lo", lo, 32'h9ABC_DEF0);
        idle_in();

        // Reset asserted mid-DIVU, away from any clock edge.
        md_valid = 1'b1; md_op = 4'd4; rs_val = 32'd1000; rt_val = 32'd3;
        tick();
        idle_in();
        repeat (3) tick();
        chk("divu pre-reset busy", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async rst busy", {31'd0, busy}, 32'd0);
        chk("async rst hi", hi, 32'd0);
        chk("async rst lo", lo, 32'd0);
        tick();
        reset = 1'b1;
        md_valid = 1'b1; md_op = 4'd8;
        #1;
        chk("post rst mflo", md_rdata, 32'd0);
        idle_in();
        repeat (12) tick();
        chk("no late hi", hi, 32'd0);
        chk("no late lo", lo, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
